// File: rtl/aes_wb_master.sv
// Wishbone B3 classic master that runs one AES block through the aes_top register map:
// key/pt writes, mode, ld pulse, status polling and ciphertext read-back.
module aes_wb_master #(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          POLL_MAX  = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_mode_i,
    input  logic          req_key_new_i,
    input  logic [127:0]  req_pt_i,
    input  logic [127:0]  req_key_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [127:0]  rsp_ct_o,
    output logic          rsp_err_o,
    output logic          rsp_timeout_o,
    output logic          busy_o,
    output logic [1:0]    state_dbg,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    typedef enum logic [1:0] {IDLE, XFER, GAP, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] dat;
    } bus_op_t;

    localparam int            PW       = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);
    localparam logic [3:0]    OP_PT    = 4'd4;
    localparam logic [3:0]    OP_POLL  = 4'd11;
    localparam logic [3:0]    OP_CT    = 4'd12;
    localparam logic [3:0]    OP_LAST  = 4'd15;

    state_t          state, state_next;
    logic [127:0]    pt_q, key_q, ct_q;
    logic            mode_q;
    logic [3:0]      op_q;
    logic [PW-1:0]   poll_cnt;
    logic            seq_done, err_q, to_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;
    logic            we_q;
    bus_op_t         load_op;
    logic            accept, load;

    // Op counter: 0-3 key, 4-7 pt, 8 mode, 9/10 ld pulse, 11 poll, 12-15 ct read-back.
    function automatic bus_op_t decode_op(input logic [3:0] op, input logic [127:0] key,
                                          input logic [127:0] pt, input logic mode);
        bus_op_t r;
        r.we  = 1'b1;
        r.idx = 4'd0;
        r.dat = 32'h0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                r.idx = 4'd5 + {2'b00, op[1:0]};
                r.dat = key[{op[1:0], 5'b0} +: 32];
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
                r.idx = 4'd1 + {2'b00, op[1:0]};
                r.dat = pt[{op[1:0], 5'b0} +: 32];
            end
            4'd8:  r.dat = {31'b0, mode};
            4'd9:  begin r.idx = 4'd9; r.dat = 32'h1; end
            4'd10: r.idx = 4'd9;
            4'd11: begin r.idx = 4'd9; r.we = 1'b0; end
            default: begin
                r.idx = 4'd10 + {2'b00, op[1:0]};
                r.we  = 1'b0;
            end
        endcase
        return r;
    endfunction

    // Request side accepts on req_valid_i & req_ready_o; response side holds rsp_* stable
    // from rsp_valid_o until the cycle with rsp_valid_o & rsp_ready_i.
    always_comb begin
        accept  = (state == IDLE) && req_valid_i;
        load    = accept || ((state == GAP) && !seq_done);
        load_op = decode_op(op_q, key_q, pt_q, mode_q);
        if (state == IDLE) begin
            load_op = decode_op(req_key_new_i ? 4'd0 : OP_PT, req_key_i, req_pt_i, req_mode_i);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        wb_stb_o    = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) state_next = XFER;
            end
            XFER: begin
                wb_stb_o = 1'b1;
                if (wb_err_i)      state_next = RESP;
                else if (wb_ack_i) state_next = GAP;
            end
            GAP:  state_next = seq_done ? RESP : XFER;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            mode_q   <= 1'b0;
            op_q     <= '0;
            poll_cnt <= '0;
            seq_done <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            if (accept) begin
                pt_q     <= req_pt_i;
                key_q    <= req_key_i;
                mode_q   <= req_mode_i;
                op_q     <= req_key_new_i ? 4'd0 : OP_PT;
                poll_cnt <= '0;
                seq_done <= 1'b0;
                err_q    <= 1'b0;
                to_q     <= 1'b0;
                ct_q     <= '0;
            end
            if (load) begin
                adr_q <= AW'(BASE_ADDR) + AW'({load_op.idx, 1'b0});
                dat_q <= DW'(load_op.dat);
                we_q  <= load_op.we;
            end
            if (state == XFER) begin
                if (wb_err_i) begin
                    err_q <= 1'b1;
                    ct_q  <= '0;
                end else if (wb_ack_i) begin
                    if (op_q == OP_POLL) begin
                        if (wb_dat_i[0]) begin
                            op_q <= OP_CT;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                            if (poll_cnt + PW'(1) == POLL_LIM) begin
                                to_q     <= 1'b1;
                                seq_done <= 1'b1;
                            end
                        end
                    end else if (op_q >= OP_CT) begin
                        // First ct read lands in [127:96] after three further shifts.
                        ct_q <= {ct_q[95:0], wb_dat_i[31:0]};
                        if (op_q == OP_LAST) seq_done <= 1'b1;
                        else                 op_q <= op_q + 4'd1;
                    end else begin
                        op_q <= op_q + 4'd1;
                    end
                end
            end
        end
    end

    assign wb_cyc_o      = wb_stb_o;
    assign wb_sel_o      = 4'hF;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_we_o       = we_q;
    assign rsp_ct_o      = ct_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = to_q;
    assign state_dbg     = state;

endmodule
